// File: rtl/stage2_message_writeback_pkg.sv
// Shared widths, destination codes and default operand value for the stage-2 writeback path.
// The optional drop counter is enabled by defining STAGE2_WB_DROP_CNT_EN.
package stage2_message_writeback_pkg;

    localparam int unsigned MAX_MESSAGE_BITS          = 32;
    localparam int unsigned MESSAGE_MUX_CONTROL_WIDTH = 3;
    localparam int unsigned NUM_LANES                 = 3;
    localparam int unsigned NUM_OPND                  = 5;

    // Destination codes; operand index order is {N,q,k,d,a}.
    localparam int unsigned MESSAGE_MUX_A = 0;
    localparam int unsigned MESSAGE_MUX_D = 1;
    localparam int unsigned MESSAGE_MUX_K = 2;
    localparam int unsigned MESSAGE_MUX_Q = 3;
    localparam int unsigned MESSAGE_MUX_N = 4;

    localparam logic [63:0] DEFAUT_MESSAGE = '0;

    function automatic logic [NUM_OPND-1:0] dest_onehot(input logic [31:0] code);
        case (code)
            MESSAGE_MUX_A: dest_onehot = 5'b00001;
            MESSAGE_MUX_D: dest_onehot = 5'b00010;
            MESSAGE_MUX_K: dest_onehot = 5'b00100;
            MESSAGE_MUX_Q: dest_onehot = 5'b01000;
            MESSAGE_MUX_N: dest_onehot = 5'b10000;
            default:       dest_onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/stage2_message_writeback_arbiter.sv
// Per-lane destination decode and fixed-priority (m1>m2>m3) collision check.
// A lane with an undefined code decodes to an empty select and never collides.
module stage2_wb_arbiter
    import stage2_message_writeback_pkg::*;
#(
    parameter int unsigned CTL_W = MESSAGE_MUX_CONTROL_WIDTH
) (
    input  logic                               clear,
    input  logic [NUM_LANES-1:0]               wb_valid,
    input  logic [NUM_LANES-1:0][CTL_W-1:0]    wb_control,
    output logic [NUM_LANES-1:0]               wb_ready,
    output logic [NUM_LANES-1:0][NUM_OPND-1:0] dest_sel,
    output logic [NUM_LANES-1:0]               code_legal
);

    always_comb begin
        wb_ready   = '0;
        dest_sel   = '0;
        code_legal = '0;
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
            dest_sel[j]   = dest_onehot(32'(wb_control[j]));
            code_legal[j] = |dest_sel[j];
        end
        // Comparing one-hot selects is equivalent to comparing codes once the lower lane is legal.
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
            wb_ready[j] = !clear;
            for (int unsigned i = 0; i < j; i++) begin
                if (wb_valid[i] && code_legal[i] && (dest_sel[i] == dest_sel[j]))
                    wb_ready[j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage2_message_writeback.sv
// Stage-2 message writeback: three lanes write five operand registers with written tracking.
// Define STAGE2_WB_DROP_CNT_EN to add the wb_drop_cnt undefined-code drop counter.
module stage2_message_writeback
    import stage2_message_writeback_pkg::*;
#(
    parameter int unsigned MSG_W = MAX_MESSAGE_BITS,
    parameter int unsigned CTL_W = MESSAGE_MUX_CONTROL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wb_valid_m1,
    input  logic             wb_valid_m2,
    input  logic             wb_valid_m3,
    output logic             wb_ready_m1,
    output logic             wb_ready_m2,
    output logic             wb_ready_m3,
    input  logic [MSG_W-1:0] message_1,
    input  logic [MSG_W-1:0] message_2,
    input  logic [MSG_W-1:0] message_3,
    input  logic [CTL_W-1:0] wb_control_m1,
    input  logic [CTL_W-1:0] wb_control_m2,
    input  logic [CTL_W-1:0] wb_control_m3,
    output logic [MSG_W-1:0] message_a,
    output logic [MSG_W-1:0] message_d,
    output logic [MSG_W-1:0] message_k,
    output logic [MSG_W-1:0] message_q,
    output logic [MSG_W-1:0] message_N,
    output logic [4:0]       written_mask,
    output logic             all_written,
    output logic             wb_code_err
`ifdef STAGE2_WB_DROP_CNT_EN
    ,
    output logic [7:0]       wb_drop_cnt
`endif
);

    logic [NUM_LANES-1:0]               lane_valid;
    logic [NUM_LANES-1:0]               lane_ready;
    logic [NUM_LANES-1:0]               code_legal;
    logic [NUM_LANES-1:0]               bad_wr;
    logic [NUM_LANES-1:0][CTL_W-1:0]    lane_ctl;
    logic [NUM_LANES-1:0][MSG_W-1:0]    lane_msg;
    logic [NUM_LANES-1:0][NUM_OPND-1:0] dest_sel;
    logic [NUM_OPND-1:0][MSG_W-1:0]     opnd_q;
    logic [NUM_OPND-1:0][MSG_W-1:0]     opnd_d;
    logic [NUM_OPND-1:0]                wr_bits;
    logic [NUM_OPND-1:0]                mask_d;

    assign lane_valid = {wb_valid_m3, wb_valid_m2, wb_valid_m1};
    assign lane_ctl   = {wb_control_m3, wb_control_m2, wb_control_m1};
    assign lane_msg   = {message_3, message_2, message_1};
    assign {wb_ready_m3, wb_ready_m2, wb_ready_m1} = lane_ready;

    stage2_wb_arbiter #(
        .CTL_W (CTL_W)
    ) u_arbiter (
        .clear      (clear),
        .wb_valid   (lane_valid),
        .wb_control (lane_ctl),
        .wb_ready   (lane_ready),
        .dest_sel   (dest_sel),
        .code_legal (code_legal)
    );

    always_comb begin
        opnd_d  = opnd_q;
        wr_bits = '0;
        bad_wr  = '0;
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
            if (lane_valid[j] && lane_ready[j]) begin
                if (code_legal[j]) begin
                    wr_bits = wr_bits | dest_sel[j];
                    for (int unsigned o = 0; o < NUM_OPND; o++) begin
                        if (dest_sel[j][o])
                            opnd_d[o] = lane_msg[j];
                    end
                end else begin
                    bad_wr[j] = 1'b1;
                end
            end
        end
        mask_d = written_mask | wr_bits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q       <= {NUM_OPND{MSG_W'(DEFAUT_MESSAGE)}};
            written_mask <= '0;
            all_written  <= 1'b0;
            wb_code_err  <= 1'b0;
        end else if (clear) begin
            opnd_q       <= {NUM_OPND{MSG_W'(DEFAUT_MESSAGE)}};
            written_mask <= '0;
            all_written  <= 1'b0;
            wb_code_err  <= 1'b0;
        end else begin
            opnd_q       <= opnd_d;
            written_mask <= mask_d;
            all_written  <= (written_mask != '1) && (mask_d == '1);
            wb_code_err  <= wb_code_err | (|bad_wr);
        end
    end

`ifdef STAGE2_WB_DROP_CNT_EN
    logic [8:0] drop_sum;

    assign drop_sum = {1'b0, wb_drop_cnt} + 9'(bad_wr[0]) + 9'(bad_wr[1]) + 9'(bad_wr[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_drop_cnt <= '0;
        else if (clear)
            wb_drop_cnt <= '0;
        else
            wb_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
`endif

    assign message_a = opnd_q[0];
    assign message_d = opnd_q[1];
    assign message_k = opnd_q[2];
    assign message_q = opnd_q[3];
    assign message_N = opnd_q[4];

endmodule

// File: tb/tb_stage2_message_writeback.sv
// Scoreboard bench for stage2_message_writeback: directed cases then randomized lane traffic.
// Build with STAGE2_WB_DROP_CNT_EN defined to also check wb_drop_cnt.
module tb_stage2_message_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        wb_valid_m1 = 1'b0, wb_valid_m2 = 1'b0, wb_valid_m3 = 1'b0;
    logic        wb_ready_m1, wb_ready_m2, wb_ready_m3;
    logic [31:0] message_1 = '0, message_2 = '0, message_3 = '0;
    logic [2:0]  wb_control_m1 = '0, wb_control_m2 = '0, wb_control_m3 = '0;
    logic [31:0] message_a, message_d, message_k, message_q, message_N;
    logic [4:0]  written_mask;
    logic        all_written;
    logic        wb_code_err;
`ifdef STAGE2_WB_DROP_CNT_EN
    logic [7:0]  wb_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage2_message_writeback #(
        .MSG_W (32),
        .CTL_W (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .wb_valid_m1   (wb_valid_m1),
        .wb_valid_m2   (wb_valid_m2),
        .wb_valid_m3   (wb_valid_m3),
        .wb_ready_m1   (wb_ready_m1),
        .wb_ready_m2   (wb_ready_m2),
        .wb_ready_m3   (wb_ready_m3),
        .message_1     (message_1),
        .message_2     (message_2),
        .message_3     (message_3),
        .wb_control_m1 (wb_control_m1),
        .wb_control_m2 (wb_control_m2),
        .wb_control_m3 (wb_control_m3),
        .message_a     (message_a),
        .message_d     (message_d),
        .message_k     (message_k),
        .message_q     (message_q),
        .message_N     (message_N),
        .written_mask  (written_mask),
        .all_written   (all_written),
        .wb_code_err   (wb_code_err)
`ifdef STAGE2_WB_DROP_CNT_EN
        ,
        .wb_drop_cnt   (wb_drop_cnt)
`endif
    );

    typedef struct {
        logic [2:0]  ready;
        logic [31:0] regs [5];
        logic [4:0]  mask;
        logic        aw;
        logic        err;
        int          cnt;
    } exp_t;

    exp_t sbq[$];
    logic mon_busy = 1'b0;

    // Reference state: operand file indexed by destination code 0..4 (a,d,k,q,N).
    logic [31:0] m_reg [5];
    logic [4:0]  m_mask;
    logic        m_aw;
    logic        m_err;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = '0;
        m_mask = '0;
        m_aw   = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    function automatic logic [31:0] dut_reg(input int idx);
        case (idx)
            0: dut_reg = message_a;
            1: dut_reg = message_d;
            2: dut_reg = message_k;
            3: dut_reg = message_q;
            default: dut_reg = message_N;
        endcase
    endfunction

    // Drive one cycle of lane inputs; push expected ready for this cycle and state after the edge.
    task automatic drive_cycle(input logic [2:0] v, input logic [2:0][2:0] c,
                               input logic [2:0][31:0] d, input logic clr,
                               output logic [2:0] rdy);
        exp_t e;
        int drops;
        logic [4:0] old_mask;
        @(posedge clk);
        #1;
        wb_valid_m1 = v[0]; wb_valid_m2 = v[1]; wb_valid_m3 = v[2];
        wb_control_m1 = c[0]; wb_control_m2 = c[1]; wb_control_m3 = c[2];
        message_1 = d[0]; message_2 = d[1]; message_3 = d[2];
        clear = clr;
        for (int j = 0; j < 3; j++) begin
            rdy[j] = !clr;
            for (int i = 0; i < j; i++)
                if (v[i] && c[i] < 5 && c[i] == c[j]) rdy[j] = 1'b0;
        end
        if (clr) begin
            model_reset();
        end else begin
            drops = 0;
            old_mask = m_mask;
            for (int j = 0; j < 3; j++) begin
                if (v[j] && rdy[j]) begin
                    if (c[j] < 5) begin
                        m_reg[c[j]] = d[j];
                        m_mask[c[j]] = 1'b1;
                    end else begin
                        m_err = 1'b1;
                        drops++;
                    end
                end
            end
            m_aw  = (old_mask != 5'h1F) && (m_mask == 5'h1F);
            m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
        end
        e.ready = rdy;
        for (int i = 0; i < 5; i++) e.regs[i] = m_reg[i];
        e.mask = m_mask;
        e.aw   = m_aw;
        e.err  = m_err;
        e.cnt  = m_cnt;
        sbq.push_back(e);
    endtask

    task automatic idle_cycle();
        logic [2:0] r;
        drive_cycle(3'b000, '0, '0, 1'b0, r);
    endtask

    task automatic drain();
        int k;
        idle_cycle();
        k = 0;
        while ((sbq.size() > 0 || mon_busy) && k < 20) begin
            @(posedge clk);
            #3;
            k++;
        end
        chk("drain_timeout", 64'(sbq.size() > 0 || mon_busy), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                mon_busy = 1'b1;
                chk("ready", {wb_ready_m3, wb_ready_m2, wb_ready_m1}, e.ready);
                @(posedge clk);
                #2;
                for (int i = 0; i < 5; i++)
                    chk($sformatf("reg%0d", i), dut_reg(i), e.regs[i]);
                chk("written_mask", written_mask, e.mask);
                chk("all_written", all_written, e.aw);
                chk("wb_code_err", wb_code_err, e.err);
`ifdef STAGE2_WB_DROP_CNT_EN
                chk("wb_drop_cnt", wb_drop_cnt, 64'(e.cnt));
`endif
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        logic [2:0] r;
        logic [2:0] pv;
        logic [2:0][2:0] pc;
        logic [2:0][31:0] pd;
        logic clr;

        model_reset();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 5; i++) chk("reset_reg", dut_reg(i), 64'd0);
        chk("reset_mask", written_mask, 64'd0);
        chk("reset_aw", all_written, 64'd0);
        chk("reset_err", wb_code_err, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {wb_ready_m3, wb_ready_m2, wb_ready_m1}, 64'h7);

        // Distinct destinations in one cycle: m1->a, m2->k, m3->N.
        drive_cycle(3'b111, {3'd4, 3'd2, 3'd0}, {32'h33, 32'h22, 32'h11}, 1'b0, r);
        // Collision on q: m1 wins, m3 retries next cycle.
        drive_cycle(3'b101, {3'd3, 3'd0, 3'd3}, {32'hBB, 32'h0, 32'hAA}, 1'b0, r);
        drive_cycle(3'b100, {3'd3, 3'd0, 3'd0}, {32'hBB, 32'h0, 32'h0}, 1'b0, r);
        idle_cycle();

        // Clear with m1 valid, then fill all five operands, then rewrite d.
        drive_cycle(3'b001, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h55}, 1'b1, r);
        for (int o = 0; o < 5; o++)
            drive_cycle(3'b001, {3'd0, 3'd0, 3'(o)}, {32'h0, 32'h0, 32'(32'h100 + o)}, 1'b0, r);
        idle_cycle();
        drive_cycle(3'b001, {3'd0, 3'd0, 3'd1}, {32'h0, 32'h0, 32'hD00D}, 1'b0, r);
        idle_cycle();

        // Undefined code on m2.
        drive_cycle(3'b010, {3'd0, 3'd6, 3'd0}, {32'h0, 32'hBAD, 32'h0}, 1'b0, r);
        idle_cycle();

        // Randomized traffic; a stalled lane holds its request until accepted.
        pv = '0; pc = '0; pd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int j = 0; j < 3; j++) begin
                if (!pv[j] && ($urandom % 10) < 6) begin
                    pv[j] = 1'b1;
                    pc[j] = (($urandom % 8) == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
                    pd[j] = $urandom;
                end
            end
            clr = (($urandom % 40) == 0);
            drive_cycle(pv, pc, pd, clr, r);
            for (int j = 0; j < 3; j++)
                if (pv[j] && r[j]) pv[j] = 1'b0;
        end
        drain();

        // Make sure operand a is non-default, then assert reset between edges mid-write.
        drive_cycle(3'b001, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0, r);
        drain();
        chk("pre_reset_a", message_a, 64'h1234);
        @(posedge clk);
        #1;
        wb_valid_m1 = 1'b1; wb_control_m1 = 3'd0; message_1 = 32'h77;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 5; i++) chk("async_reset_reg", dut_reg(i), 64'd0);
        chk("async_reset_mask", written_mask, 64'd0);
        chk("async_reset_err", wb_code_err, 64'd0);
        @(posedge clk);
        #1;
        chk("reset_hold_a", message_a, 64'd0);
        wb_valid_m1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        drive_cycle(3'b111, {3'd1, 3'd7, 3'd1}, {32'h9, 32'h8, 32'h7}, 1'b0, r);
        drive_cycle(3'b100, {3'd1, 3'd0, 3'd0}, {32'h9, 32'h0, 32'h0}, 1'b0, r);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
